// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin arbiter/sequencer for two requesters sharing one
// single-port BRAM (registered read data, 1-cycle latency).
// After reset it zero-fills every BRAM word (DEPTH cycles), raises init_done,
// then grants the port to A or B, alternating when both are valid.
// Ports:
//   clk, rst (async, active-low)
//   a_*/b_*   : requester command (valid/we/addr/wdata), ready (comb),
//               read return (rvalid pulse, rdata held for non-owner)
//   bram_*    : registered drive to BRAM write_enable/read_enable/addr/data_in,
//               bram_dout from BRAM data_out
//   init_done : high once the zero-fill has completed
// Optional: define BRAM_ARB_STATS_EN to add stat_a_grants/stat_b_grants,
// 16-bit saturating counts of accepted commands per requester.
module bram_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ready,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ready,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  bram_we,
  output logic                  bram_re,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  init_done
`ifdef BRAM_ARB_STATS_EN
  ,
  output logic [15:0]           stat_a_grants,
  output logic [15:0]           stat_b_grants
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Read-return tag: one entry per pipeline stage.
  typedef struct packed {
    logic vld;
    logic own_b;
  } tag_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    rr_b_q, rr_b_d;   // 1 = B has priority on a tie
  tag_t                    tag1_q, tag1_d, tag2_q;

  logic                    bram_we_d, bram_re_d, init_done_d;
  logic [ADDR_WIDTH-1:0]   bram_addr_d;
  logic [DATA_WIDTH-1:0]   bram_din_d;
  logic                    a_rvalid_d, b_rvalid_d;
  logic [DATA_WIDTH-1:0]   a_rdata_d, b_rdata_d;

  logic                    run, a_fire, b_fire, cmd_we;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;

  // Grant logic: a lone requester always wins; on a tie the pointer decides.
  assign run       = (state_q == ST_RUN);
  assign a_ready   = run & a_valid & (~b_valid | ~rr_b_q);
  assign b_ready   = run & b_valid & (~a_valid |  rr_b_q);
  assign a_fire    = a_valid & a_ready;
  assign b_fire    = b_valid & b_ready;
  assign cmd_we    = b_fire ? b_we    : a_we;
  assign cmd_addr  = b_fire ? b_addr  : a_addr;
  assign cmd_wdata = b_fire ? b_wdata : a_wdata;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_INIT;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (cnt_q == LAST_ADDR) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Output/datapath next values.
  always_comb begin
    bram_we_d   = 1'b0;
    bram_re_d   = 1'b0;
    bram_addr_d = bram_addr;
    bram_din_d  = bram_din;
    init_done_d = init_done;
    cnt_d       = cnt_q;
    rr_b_d      = rr_b_q;
    tag1_d      = '0;
    case (state_q)
      ST_INIT: begin
        bram_we_d   = 1'b1;
        bram_addr_d = cnt_q;
        bram_din_d  = '0;
        cnt_d       = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_ADDR) init_done_d = 1'b1;
      end
      ST_RUN: begin
        if (a_fire | b_fire) begin
          bram_we_d    = cmd_we;
          bram_re_d    = ~cmd_we;
          bram_addr_d  = cmd_addr;
          bram_din_d   = cmd_wdata;
          rr_b_d       = a_fire;
          tag1_d.vld   = ~cmd_we;
          tag1_d.own_b = b_fire;
        end
      end
      default: ;
    endcase

    // Stage 2 of the tag pipeline lines up with valid bram_dout.
    a_rvalid_d = tag2_q.vld & ~tag2_q.own_b;
    b_rvalid_d = tag2_q.vld &  tag2_q.own_b;
    a_rdata_d  = a_rvalid_d ? bram_dout : a_rdata;
    b_rdata_d  = b_rvalid_d ? bram_dout : b_rdata;
  end

  // Registered outputs and pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      rr_b_q    <= 1'b0;
      tag1_q    <= '0;
      tag2_q    <= '0;
      bram_we   <= 1'b0;
      bram_re   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      init_done <= 1'b0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rr_b_q    <= rr_b_d;
      tag1_q    <= tag1_d;
      tag2_q    <= tag1_q;
      bram_we   <= bram_we_d;
      bram_re   <= bram_re_d;
      bram_addr <= bram_addr_d;
      bram_din  <= bram_din_d;
      init_done <= init_done_d;
      a_rvalid  <= a_rvalid_d;
      b_rvalid  <= b_rvalid_d;
      a_rdata   <= a_rdata_d;
      b_rdata   <= b_rdata_d;
    end
  end

`ifdef BRAM_ARB_STATS_EN
  // Saturating grant counters; grants only exist in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_a_grants <= '0;
      stat_b_grants <= '0;
    end else begin
      if (a_fire && stat_a_grants != 16'hFFFF) stat_a_grants <= stat_a_grants + 16'd1;
      if (b_fire && stat_b_grants != 16'hFFFF) stat_b_grants <= stat_b_grants + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter with a behavioural single-port BRAM.
module tb_bram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, a_we, b_valid, b_we;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ready, a_rvalid, b_ready, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       bram_we, bram_re, init_done;
  logic [3:0] bram_addr;
  logic [7:0] bram_din;
  logic [7:0] bram_dout;
`ifdef BRAM_ARB_STATS_EN
  logic [15:0] stat_a_grants, stat_b_grants;
`endif

  bram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .bram_we(bram_we), .bram_re(bram_re), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout), .init_done(init_done)
`ifdef BRAM_ARB_STATS_EN
    , .stat_a_grants(stat_a_grants), .stat_b_grants(stat_b_grants)
`endif
  );

  always #5 clk = ~clk;

  // BRAM model, preloaded with non-zero junk so the zero-fill is visible.
  logic [7:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
    bram_dout = 8'h00;
  end
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_din;
    if (bram_re) bram_dout <= mem[bram_addr];
  end

  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        own_b;
    logic [7:0]  data;
    logic [31:0] cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expected read return whenever either rvalid is seen.
  always @(negedge clk) begin
    if (rst && (a_rvalid || b_rvalid)) begin
      exp_t e;
      chk("rvalid_exclusive", {31'd0, a_rvalid & b_rvalid}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rvalid_owner", {31'd0, b_rvalid}, {31'd0, e.own_b});
        chk("rdata", {24'd0, (b_rvalid ? b_rdata : a_rdata)}, {24'd0, e.data});
        chk("read_latency", cyc, e.cyc);
      end
    end
  end

  // Issue one command and wait (bounded) for acceptance; reads push their
  // hand-computed expected return when push is set.
  task automatic issue(input bit own_b, input bit we, input logic [3:0] addr,
                       input logic [7:0] wd, input logic [7:0] exp_d,
                       input bit push, output int waits);
    bit done;
    waits = 0;
    done  = 0;
    @(negedge clk);
    if (own_b) begin b_valid = 1; b_we = we; b_addr = addr; b_wdata = wd; end
    else       begin a_valid = 1; a_we = we; a_addr = addr; a_wdata = wd; end
    while (!done) begin
      #1;
      if (own_b ? b_ready : a_ready) begin
        if (!we && push) sb.push_back({own_b, exp_d, cyc + 32'd3});
        done = 1;
      end else begin
        waits++;
        if (waits > 20) begin
          chk("accept_timeout", 32'd1, 32'd0);
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
    @(posedge clk);
    #1;
    if (own_b) b_valid = 0; else a_valid = 0;
  endtask

  // Checks the DEPTH-cycle zero-fill right after rst is released at a negedge,
  // with both requesters pressing valid throughout.
  task automatic check_init();
    a_valid = 1; a_we = 0; a_addr = 4'd0;
    b_valid = 1; b_we = 0; b_addr = 4'd0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("init_we", {31'd0, bram_we}, 32'd1);
      chk("init_re", {31'd0, bram_re}, 32'd0);
      chk("init_addr", {28'd0, bram_addr}, k - 1);
      chk("init_din", {24'd0, bram_din}, 32'd0);
      chk("init_done_rise", {31'd0, init_done}, {31'd0, (k == 16)});
      if (k < 16) chk("init_ready", {30'd0, a_ready, b_ready}, 32'd0);
    end
    a_valid = 0;
    b_valid = 0;
  endtask

  int w;

  initial begin
    rst = 0;
    a_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0;

    // Reset state, with A pressing valid to show ready stays low.
    repeat (3) @(negedge clk);
    a_valid = 1;
    #1;
    chk("rst_outputs", {bram_we, bram_re, init_done, a_rvalid, b_rvalid, a_ready, b_ready},
        32'd0);
    chk("rst_addr_din", {20'd0, bram_addr, bram_din}, 32'd0);
    chk("rst_rdata", {16'd0, a_rdata, b_rdata}, 32'd0);
    a_valid = 0;

    @(negedge clk);
    rst = 1;
    check_init();

    // A reads address 5 after init: zero.
    issue(0, 0, 4'd5, 8'h00, 8'h00, 1, w);
    // A writes A5 to 3 then immediately reads it back.
    issue(0, 1, 4'd3, 8'hA5, 8'h00, 1, w);
    issue(0, 0, 4'd3, 8'h00, 8'hA5, 1, w);
    chk("wr_rd_back_to_back", w, 32'd0);
    // Seed addresses 1/2; the B write leaves A with tie priority.
    issue(0, 1, 4'd1, 8'h11, 8'h00, 1, w);
    issue(1, 1, 4'd2, 8'h22, 8'h00, 1, w);

    // Both requesters hold reads for 4 cycles: grants A,B,A,B.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_valid = 1; a_we = 0; a_addr = 4'd1;
      b_valid = 1; b_we = 0; b_addr = 4'd2;
      #1;
      chk("alt_a_ready", {31'd0, a_ready}, {31'd0, (i % 2 == 0)});
      chk("alt_b_ready", {31'd0, b_ready}, {31'd0, (i % 2 == 1)});
      if (a_ready)      sb.push_back({1'b0, 8'h11, cyc + 32'd3});
      else if (b_ready) sb.push_back({1'b1, 8'h22, cyc + 32'd3});
    end
    @(posedge clk);
    #1;
    a_valid = 0;
    b_valid = 0;

    // B writes 3C to 15 while A idle: accepted immediately.
    issue(1, 1, 4'd15, 8'h3C, 8'h00, 1, w);
    chk("b_lone_ready_same_cycle", w, 32'd0);
    issue(0, 0, 4'd15, 8'h00, 8'h3C, 1, w);
    repeat (4) @(negedge clk);
    chk("sb_drained_mid", sb.size(), 32'd0);

    // A read accepted, then reset one cycle later: no return, fill restarts.
    issue(0, 0, 4'd15, 8'h00, 8'h3C, 0, w);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_mid_init_done", {31'd0, init_done}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    end
`ifdef BRAM_ARB_STATS_EN
    chk("stat_a_after_rst", {16'd0, stat_a_grants}, 32'd0);
    chk("stat_b_after_rst", {16'd0, stat_b_grants}, 32'd0);
`endif
    rst = 1;
    check_init();
`ifdef BRAM_ARB_STATS_EN
    chk("stat_a_no_init_count", {16'd0, stat_a_grants}, 32'd0);
`endif
    issue(0, 0, 4'd15, 8'h00, 8'h00, 1, w);
`ifdef BRAM_ARB_STATS_EN
    chk("stat_a_one", {16'd0, stat_a_grants}, 32'd1);
    chk("stat_b_zero", {16'd0, stat_b_grants}, 32'd0);
`endif
    repeat (5) @(negedge clk);
    chk("sb_drained_end", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the team's single-port BRAM (write_enable / read_enable / address / data_in / data_out, read data registered 1 cycle).
- After reset it zero-fills every BRAM location, then shares the one port between requesters A and B.
- Read data is returned to the owning requester.
- Sits between client logic and the BRAM instance; the BRAM's own reset is tied inactive.

Parameters:
- DATA_WIDTH, 8, BRAM word width
- ADDR_WIDTH, 4, BRAM address width; DEPTH = 1 << ADDR_WIDTH

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- a_valid  in  1  requester A command valid
- a_we  in  1  A: 1 = write, 0 = read
- a_addr  in  ADDR_WIDTH  A address
- a_wdata  in  DATA_WIDTH  A write data
- a_ready  out  1  A command accepted this cycle (combinational)
- a_rvalid  out  1  A read data valid, one-cycle pulse
- a_rdata  out  DATA_WIDTH  A read data
- b_valid, b_we, b_addr, b_wdata, b_ready, b_rvalid, b_rdata: same as A, for requester B
- bram_we  out  1  to BRAM write_enable
- bram_re  out  1  to BRAM read_enable
- bram_addr  out  ADDR_WIDTH  to BRAM address
- bram_din  out  DATA_WIDTH  to BRAM data_in
- bram_dout  in  DATA_WIDTH  from BRAM data_out
- init_done  out  1  high once zero-fill is complete

Behaviour:
- Reset (rst=0, async): FSM=INIT, init counter=0, rr pointer favours A, all outputs 0, response pipeline cleared.
- FSM INIT:
  - Each cycle, register bram_we=1, bram_addr=counter, bram_din=0; counter increments.
  - After writing DEPTH-1, go to RUN and set init_done=1.
  - INIT lasts exactly DEPTH cycles; a_ready=b_ready=0 throughout.
- FSM RUN, each cycle:
  - Only one valid: that requester gets ready=1.
  - Both valid: grant the one not granted most recently.
  - Neither valid: no grant; rr pointer holds.
- Transfer happens when valid && ready. Requesters must hold command fields stable until accepted.
- Accepted command registered to the bram_* outputs on the accept edge E0:
  - write: bram_we=1, bram_re=0
  - read: bram_re=1, bram_we=0
  - Idle cycle: bram_we = bram_re = 0; addr/din hold last value.
- Read return:
  - BRAM samples at E1; bram_dout is valid after E1.
  - Owner's rvalid/rdata registered at E2, i.e. rvalid is high for the single cycle after E2.
  - Read latency from acceptance = 2 cycles; back-to-back reads give 1 result per cycle.
  - Owner tag travels in a 2-stage {valid, owner} pipeline.
  - Non-owner rdata holds its previous value.
- Writes produce no response.
- Read and write to the same address in consecutive grants: accept order is preserved. A read accepted one cycle after a write returns the new data.
- No response backpressure; requesters must always accept rvalid.
- Reset asserted mid-operation: in-flight reads are dropped (no rvalid) and zero-fill restarts from address 0.
- Address wrap is not applicable; addresses use the full ADDR_WIDTH range with no checking.

Optional Feature:
- Macro BRAM_ARB_STATS_EN.
- Defined: adds outputs stat_a_grants and stat_b_grants, 16 bits each.
  - Each increments on its requester's accepted command and saturates at 16'hFFFF.
  - Both reset to 0, including on reset mid-count.
  - Neither counts during INIT.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, no requests: init_done rises exactly 16 cycles after rst deasserts. bram_we is high for 16 cycles with bram_addr 0..15, bram_din=0. a_ready=b_ready=0 until then.
- After init, A reads addr 5: a_rvalid pulses 2 cycles after acceptance with a_rdata=8'h00; b_rvalid stays 0.
- A writes 8'hA5 to addr 3, then immediately reads addr 3: a_rdata=8'hA5 two cycles after the read is accepted.
- A and B both hold valid reads (addr 1 and 2) for 4 cycles: grants alternate A,B,A,B. rvalid pulses alternate a,b,a,b with 1-cycle spacing.
- B writes 8'h3C to addr 15 while A is idle: b_ready=1 the same cycle. A later A read of addr 15 returns 8'h3C.
- Reset asserted 1 cycle after an A read is accepted: no a_rvalid appears, init_done drops to 0, and zero-fill repeats (addr 15 reads back 8'h00 afterwards). With BRAM_ARB_STATS_EN defined, the grant counters read 0.
